apb_timer_master_arbiter: RTL

//  Shares the timer's APB slave port between NUM_REQ on-chip requesters, e.g. core

---
 rtl/apb_timer_master_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/apb_timer_master_arbiter.sv
// Round-robin APB master that shares the timer slave port between NUM_REQ requesters.
// Latency: req sampled -> gnt/SETUP +1 -> ACCESS +2 -> done +3; back-to-back SETUP after ACCESS.
module apb_timer_master_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  input  logic [31:0]             PRDATA,
  input  logic                    pslverr
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  cand;
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;
  logic [PW:0]         rr_sum;
  logic [PW-1:0]       rr_idx;
  logic                launch;

  // The requester just served may still be holding req while its gnt propagates.
  always_comb begin
    cand = req;
    if (state_q == ST_ACCESS) cand[win_q] = 1'b0;
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(NUM_REQ)) rr_sum = rr_sum - (PW+1)'(NUM_REQ);
      rr_idx = rr_sum[PW-1:0];
      if (!pick_vld && cand[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx;
      end
    end
  end

  assign launch = pick_vld && (state_q == ST_IDLE || state_q == ST_ACCESS);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: ;
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        rdata_d        = pwrite_q ? 32'h0 : PRDATA;
        err_d          = pslverr;
        done_d[win_q]  = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d          = ST_SETUP;
      win_d            = pick_idx;
      ptr_d            = (pick_idx == PW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      psel_d           = 1'b1;
      gnt_d[pick_idx]  = 1'b1;
      pwrite_d         = req_write[pick_idx];
      paddr_d          = req_addr[32*pick_idx +: 32];
      pwdata_d         = req_wdata[32*pick_idx +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule
